// File: rtl/shared_reg_pkg.sv
// Shared definitions for the shared-register arbiter: FSM state encoding and
// default sizing constants.
package shared_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_NREQ     = 4;
    localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational rotating-priority picker: the first unmasked request at or
// after ptr (wrapping) wins.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_oh,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    logic [NREQ-1:0] eff;

    always_comb begin
        int pos;
        pos    = 0;
        eff    = req & ~mask;
        gnt_oh = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            pos = (int'(ptr) + k) % NREQ;
            if (!valid && eff[pos]) begin
                valid       = 1'b1;
                gnt_oh[pos] = 1'b1;
                idx         = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting write access to one shared enabled register,
// with optional bounded lock (HOLD) by the current owner.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NREQ     = DEF_NREQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           lock,
    input  logic [NREQ*WIDTH-1:0]     wdata,
    output logic [NREQ-1:0]           gnt,
    output logic                      reg_en,
    output logic [WIDTH-1:0]          reg_d,
    output logic [$clog2(NREQ)-1:0]   owner,
    input  logic [WIDTH-1:0]          reg_q,
    output logic [WIDTH-1:0]          rdata
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_HOLD + 1);

    state_e           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             reg_en_q, reg_en_d;
    logic [WIDTH-1:0] reg_d_q, reg_d_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    hold_cnt_q, hold_cnt_d;

    logic [WIDTH-1:0] wd [NREQ];
    logic             active, cur_req, cur_lock, count_ok, keep, forced, other_pending;
    logic [NREQ-1:0]  owner_mask, pick_mask, pick_oh;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;

    for (genvar g = 0; g < NREQ; g++) begin : g_wd
        assign wd[g] = wdata[g*WIDTH +: WIDTH];
    end

    // The owner that was just served is excluded from the next arbitration;
    // a forced release may fall back to the same owner when nobody else waits.
    always_comb begin
        active        = (state_q != ST_IDLE);
        cur_req       = req[owner_q];
        cur_lock      = lock[owner_q];
        count_ok      = (int'(hold_cnt_q) + 1) < MAX_HOLD;
        keep          = active && cur_req && cur_lock && count_ok;
        forced        = active && cur_req && cur_lock && !count_ok;
        owner_mask    = active ? (NREQ'(1) << owner_q) : '0;
        other_pending = |(req & ~owner_mask);
        pick_mask     = (forced && !other_pending) ? '0 : owner_mask;
    end

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req    (req),
        .mask   (pick_mask),
        .ptr    (ptr_q),
        .gnt_oh (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        state_d    = ST_IDLE;
        gnt_d      = '0;
        reg_en_d   = 1'b0;
        reg_d_d    = reg_d_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        if (keep) begin
            state_d    = ST_HOLD;
            gnt_d      = gnt_q;
            reg_en_d   = 1'b1;
            reg_d_d    = wd[owner_q];
            hold_cnt_d = hold_cnt_q + 1'b1;
        end else if (pick_valid) begin
            state_d    = ST_GRANT;
            gnt_d      = pick_oh;
            reg_en_d   = 1'b1;
            reg_d_d    = wd[pick_idx];
            owner_d    = pick_idx;
            ptr_d      = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            reg_en_q   <= 1'b0;
            reg_d_q    <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            reg_en_q   <= reg_en_d;
            reg_d_q    <= reg_d_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt    = gnt_q;
    assign reg_en = reg_en_q;
    assign reg_d  = reg_d_q;
    assign owner  = owner_q;
    assign rdata  = reg_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (WIDTH=8, NREQ=4, MAX_HOLD=8).
module tb_shared_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, lock, gnt;
    logic [31:0] wdata;
    logic        reg_en;
    logic [7:0]  reg_d, reg_q, rdata;
    logic [1:0]  owner;

    int passed = 0;
    int total  = 0;
    logic [3:0] gnt_or;

    shared_reg_arbiter #(.WIDTH(8), .NREQ(4), .MAX_HOLD(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .lock   (lock),
        .wdata  (wdata),
        .gnt    (gnt),
        .reg_en (reg_en),
        .reg_d  (reg_d),
        .owner  (owner),
        .reg_q  (reg_q),
        .rdata  (rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        logic [3:0] exp_seq [5];
        logic [7:0] exp_dat [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

        rst_n = 1'b0; req = '0; lock = '0; wdata = '0; reg_q = 8'h3C;
        #12;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_reg_en", 32'(reg_en), 0);
        chk("rst_reg_d", 32'(reg_d), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rdata", 32'(rdata), 32'h3C);
        reg_q = 8'hC3;
        #1;
        chk("rdata2", 32'(rdata), 32'hC3);
        @(negedge clk);
        rst_n = 1'b1;

        // single request
        req = 4'b0001; wdata[7:0] = 8'hA5;
        tick();
        chk("single_gnt", 32'(gnt), 32'b0001);
        chk("single_en", 32'(reg_en), 1);
        chk("single_d", 32'(reg_d), 32'hA5);
        chk("single_owner", 32'(owner), 0);
        chk("single_ptr", 32'(dut.ptr_q), 1);
        req = '0;
        tick();
        chk("single_release_gnt", 32'(gnt), 0);
        chk("single_release_en", 32'(reg_en), 0);

        // all requesting, from fresh reset
        rst_n = 1'b0; #1; rst_n = 1'b1;
        req = 4'b1111; wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_gnt", 32'(gnt), 32'(exp_seq[k]));
            chk("rr_d", 32'(reg_d), 32'(exp_dat[k]));
        end
        req = '0;
        tick();
        chk("rr_idle", 32'(gnt), 0);

        // lock hold forced release at MAX_HOLD, ptr is 1
        req = 4'b0100; lock = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            wdata[23:16] = 8'h50 + 8'(k);
            wdata[15:8]  = 8'h77;
            tick();
            chk("hold_gnt", 32'(gnt), 32'b0100);
            chk("hold_d", 32'(reg_d), 32'h50 + k);
            req = 4'b0110;
        end
        tick();
        chk("forced_gnt", 32'(gnt), 32'b0010);
        chk("forced_d", 32'(reg_d), 32'h77);
        req = '0; lock = '0;
        tick();
        chk("forced_idle", 32'(gnt), 0);

        // lock drop after 3 cycles, ptr is 2
        req = 4'b1000; lock = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("lockdrop_gnt", 32'(gnt), 32'b1000);
        end
        lock = '0;
        tick();
        chk("lockdrop_gnt_idle", 32'(gnt), 0);
        chk("lockdrop_en", 32'(reg_en), 0);
        req = '0;

        // lock without request
        lock = 4'b0001;
        tick();
        chk("lock_only", 32'(gnt), 0);
        lock = '0;

        // reset during HOLD, ptr is 0
        req = 4'b0100; lock = 4'b0100;
        tick();
        tick();
        chk("pre_rst_hold", 32'(gnt), 32'b0100);
        rst_n = 1'b0;
        #1;
        chk("async_gnt", 32'(gnt), 0);
        chk("async_en", 32'(reg_en), 0);
        chk("async_d", 32'(reg_d), 0);
        rst_n = 1'b1;
        req = 4'b1010; lock = '0;
        tick();
        chk("post_rst_gnt", 32'(gnt), 32'b0010);
        chk("post_rst_owner", 32'(owner), 1);
        req = 4'b1000;
        tick();
        chk("post_rst_gnt2", 32'(gnt), 32'b1000);
        req = '0;
        tick();
        chk("post_rst_idle", 32'(gnt), 0);

        // withdrawn request while 0 holds
        gnt_or = '0;
        req = 4'b0001; lock = 4'b0001;
        tick(); gnt_or |= gnt;
        chk("wd_gnt0", 32'(gnt), 32'b0001);
        req = 4'b0011;
        tick(); gnt_or |= gnt;
        req = 4'b0001;
        tick(); gnt_or |= gnt;
        req = '0; lock = '0;
        tick(); gnt_or |= gnt;
        tick(); gnt_or |= gnt;
        chk("withdrawn_never", 32'(gnt_or[1]), 0);
        chk("withdrawn_idle", 32'(gnt), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter WIDTH, 8, data width of the shared enabled register.
REQ-002 Parameter NREQ, 4, number of requesters (2..8).
REQ-003 Parameter MAX_HOLD, 8, maximum consecutive cycles one locked owner may keep the register.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  NREQ  per-requester write request; held high until granted.
REQ-007 lock  input  NREQ  per-requester request to keep ownership after the current grant.
REQ-008 wdata  input  NREQ*WIDTH  per-requester write data; slice i = wdata[i*WIDTH +: WIDTH].
REQ-009 gnt  output  NREQ  registered one-hot grant; bit i high = requester i's data written this cycle.
REQ-010 reg_en  output  1  enable to the shared register; registered; equals |gnt.
REQ-011 reg_d  output  WIDTH  data to the shared register; registered; granted requester's wdata.
REQ-012 owner  output  clog2(NREQ)  index of last granted requester; holds after release.
REQ-013 reg_q  input  WIDTH  shared register output, passed to rdata unmodified.
REQ-014 rdata  output  WIDTH  combinational copy of reg_q for all requesters.

Function
REQ-015 FSM states IDLE, GRANT, HOLD; exactly one active.
REQ-016 IDLE: no req -> stay IDLE, gnt=0, reg_en=0; any req -> GRANT next cycle.
REQ-017 Arbitration: round-robin from pointer ptr; first i = ptr, ptr+1, ... (mod NREQ) with req[i]=1 wins.
REQ-018 Latency: req sampled at edge N -> gnt, reg_en, reg_d valid after edge N+1 (one cycle); register captures on edge N+2.
REQ-019 gnt high for exactly one cycle per grant unless in HOLD; requester drops req the cycle after seeing gnt.
REQ-020 After grant to i, ptr <= (i+1) mod NREQ; wrap from NREQ-1 to 0.
REQ-021 GRANT with lock[i]=1 and req[i]=1 for the winner -> HOLD; gnt[i] and reg_en stay high, reg_d tracks wdata[i] each cycle (registered).
REQ-022 HOLD exits when lock[i] or req[i] drops, or hold count reaches MAX_HOLD; exit -> GRANT if any other req pending, else IDLE.
REQ-023 Forced release at MAX_HOLD: winner's req is masked for the next arbitration; another pending requester wins if present, else i may be regranted.
REQ-024 Hold counter clears on every new grant; counts cycles gnt stays high; width clog2(MAX_HOLD+1).
REQ-025 GRANT with no pending req -> IDLE; with pending reqs -> new grant on consecutive cycles (back-to-back, no bubble).
REQ-026 Simultaneous req on all lines: each granted once within NREQ grants, in ptr order.
REQ-027 A req that drops before grant is silently withdrawn; no gnt issued for it.
REQ-028 lock without req is ignored.

Reset
REQ-029 rst_n low asynchronously forces state=IDLE, gnt=0, reg_en=0, reg_d=0, owner=0, ptr=0, hold count=0.
REQ-030 Reset mid-HOLD or mid-GRANT aborts immediately; no partial write (reg_en low from reset assertion).
REQ-031 First arbitration after release of rst_n gives requester 0 highest priority.

Structure
REQ-032 Package shared_reg_pkg holds state enum type, default WIDTH/NREQ/MAX_HOLD constants.
REQ-033 One sub-module rr_pick: combinational rotating-priority picker (req, mask, ptr -> one-hot, index, valid).
REQ-034 All outputs except rdata driven directly from flops.

Verification (WIDTH=8, NREQ=4, MAX_HOLD=8)
REQ-035 Reset, req=0001 wdata[0]=0xA5 -> gnt=0001, reg_en=1, reg_d=0xA5 one cycle after req; owner=0; ptr=1.
REQ-036 req=1111 held constant, no lock -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles.
REQ-037 req[2]=lock[2]=1, req[1]=1 -> gnt=0100 for 8 cycles, then gnt=0010 next cycle.
REQ-038 req[3]=lock[3]=1, drop lock after 3 cycles with no other req -> gnt=1000 for 3 cycles, then IDLE, reg_en=0.
REQ-039 rst_n pulsed low during HOLD -> gnt=0, reg_en=0, reg_d=0 without clock edge; req=1010 after release -> gnt=0010 first.
REQ-040 req[1] raised then dropped before its grant while req[0] is granted -> gnt[1] never asserts.
